div_wb_ctrl: RTL and testbench
==============================

DIV_WB_CTRL -- requirements
Module: div_wb_ctrl

Interface
REQ-001 Parameter XLEN, default 64, shall set the data width of the regfile write path.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_valid_i  in  1  ID holds a valid instruction.
REQ-005 id_div_en_i  in  1  ID instruction is a mul/div op (decoder DivEn).
REQ-006 id_div_sel_i  in  3  decoder DivSel for that op.
REQ-007 id_rd_i, id_rs1_i, id_rs2_i  in  5 each  ID destination and source indices.
REQ-008 id_rs1_used_i, id_rs2_used_i, id_wben_i  in  1 each  source-read and write-back qualifiers from ID.
REQ-009 flush_i  in  1  ID instruction is being killed this cycle.
REQ-010 div_start_o  out  1  one-cycle start pulse to the multi-cycle divider.
REQ-011 div_sel_o  out  3  op select to the divider, valid with div_start_o.
REQ-012 div_done_i  in  1  one-cycle divider completion pulse; div_result_i  in  XLEN  result, valid with div_done_i.
REQ-013 pipe_wb_en_i  in  1, pipe_wb_rd_i  in  5, pipe_wb_data_i  in  XLEN  normal pipeline write-back request.
REQ-014 rf_wr_en_o  out  1, rf_wr_addr_o  out  5, rf_wr_data_o  out  XLEN  the single regfile write port.
REQ-015 stall_o  out  1  freeze PC/IF/ID this cycle.
REQ-016 busy_o  out  1  state is not IDLE.
REQ-017 stall_cnt_o  out  32  count of cycles with stall_o=1.

Function
REQ-018 FSM states IDLE, BUSY, HOLD; registers pend_rd(5), hold_data(XLEN).
REQ-019 issue = id_valid_i & id_div_en_i & ~flush_i & ~stall_o & (state==IDLE).
REQ-020 On issue: div_start_o=1 same cycle (combinational), div_sel_o=id_div_sel_i, pend_rd <= (id_wben_i ? id_rd_i : 0), next state BUSY.
REQ-021 BUSY & div_done_i & ~pipe_wb_en_i: write div_result_i to pend_rd on the regfile port same cycle; next IDLE.
REQ-022 BUSY & div_done_i & pipe_wb_en_i: pipeline wins port; hold_data <= div_result_i; next HOLD.
REQ-023 HOLD & ~pipe_wb_en_i: write hold_data to pend_rd; next IDLE. HOLD & pipe_wb_en_i: remain HOLD.
REQ-024 div_done_i outside BUSY shall be ignored.
REQ-025 Port mux: pipeline request when pipe_wb_en_i=1 (addr/data passthrough, zero latency); else divider write per REQ-021/023; else rf_wr_en_o=0, addr/data 0.
REQ-026 Any write with address 0 shall drive rf_wr_en_o=0 (divider op with pend_rd=0 still runs to completion and sequences states).
REQ-027 hazard = (state!=IDLE) & pend_rd!=0 & ((id_rs1_used_i & id_rs1_i==pend_rd) | (id_rs2_used_i & id_rs2_i==pend_rd) | (id_wben_i & id_rd_i==pend_rd)).
REQ-028 stall_o = id_valid_i & ~flush_i & ((id_div_en_i & state!=IDLE) | hazard); computed from current state, so stall holds through the cycle of the divider write and releases the next cycle.
REQ-029 No forwarding of div result; consumers read regfile after release.
REQ-030 stall_cnt_o increments by 1 each cycle stall_o=1, wraps 0xFFFFFFFF -> 0.
REQ-031 flush_i does not cancel an already issued divide; it continues to write back.

Reset
REQ-032 While rst=1 at a clock edge: state<=IDLE, pend_rd<=0, hold_data<=0, stall_cnt_o<=0.
REQ-033 Reset mid-divide abandons the op; a later div_done_i is ignored (REQ-024); no regfile write.
REQ-034 During reset cycle outputs follow REQ-025/028 from IDLE state: div_start_o=0 unless issue conditions hold only after reset deasserts.

Verification
REQ-035 Issue div rd=5, done after 10 cycles, no pipe wb -> start pulse 1 cycle, busy_o=1 for 10 cycles, rf write x5=result on done cycle, busy_o=0 next cycle.
REQ-036 While BUSY (pend_rd=5) ID reads rs1=5 -> stall_o=1 until cycle after write; ID reads rs1=6 -> stall_o=0; second div in ID -> stall_o=1.
REQ-037 div_done_i coincident with pipe wb x7=0x11 for 3 cycles -> x7 written 3 cycles, then x5=held result in 4th cycle, state HOLD->IDLE.
REQ-038 Div with rd=0 -> start pulse, no rf write, stall_o never asserted on rs==0.
REQ-039 rst during BUSY then div_done_i -> no rf write, state IDLE, stall_cnt_o=0.
REQ-040 Preload stall_cnt_o to 0xFFFFFFFF via 2^32-1 stalls (or force) plus one stall -> 0.

Source files
------------

// File: rtl/div_wb_ctrl.sv
// Sequences a multi-cycle divider against the single regfile write port.
// It also stalls ID on structural and RAW/WAW hazards with the pending destination.
module div_wb_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic            id_div_en_i,
    input  logic [2:0]      id_div_sel_i,
    input  logic [4:0]      id_rd_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic            id_wben_i,
    input  logic            flush_i,
    output logic            div_start_o,
    output logic [2:0]      div_sel_o,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] div_result_i,
    input  logic            pipe_wb_en_i,
    input  logic [4:0]      pipe_wb_rd_i,
    input  logic [XLEN-1:0] pipe_wb_data_i,
    output logic            rf_wr_en_o,
    output logic [4:0]      rf_wr_addr_o,
    output logic [XLEN-1:0] rf_wr_data_o,
    output logic            stall_o,
    output logic            busy_o,
    output logic [31:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_eff;
    state_t            w_next;
    logic [4:0]        r_pend_rd;
    logic [XLEN-1:0]   r_hold_data;
    logic [31:0]       r_stall_cnt;
    logic              w_hazard;
    logic              w_stall;
    logic              w_issue;
    logic              w_div_wr;
    logic              w_hold_cap;
    logic [XLEN-1:0]   w_div_data;

    // Hazard, stall and issue decode; reset makes the controller look idle.
    always_comb begin
        w_state_eff = rst ? S_IDLE : r_state;
        w_hazard    = (w_state_eff != S_IDLE) && (r_pend_rd != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_i == r_pend_rd)) ||
                       (id_rs2_used_i && (id_rs2_i == r_pend_rd)) ||
                       (id_wben_i     && (id_rd_i  == r_pend_rd)));
        w_stall     = id_valid_i && !flush_i &&
                      ((id_div_en_i && (w_state_eff != S_IDLE)) || w_hazard);
        w_issue     = id_valid_i && id_div_en_i && !flush_i && !w_stall &&
                      (w_state_eff == S_IDLE) && !rst;
        w_div_wr    = !pipe_wb_en_i &&
                      (((w_state_eff == S_BUSY) && div_done_i) || (w_state_eff == S_HOLD));
        w_hold_cap  = (w_state_eff == S_BUSY) && div_done_i && pipe_wb_en_i;
        w_div_data  = (w_state_eff == S_HOLD) ? r_hold_data : div_result_i;
    end

    // Regfile port mux: pipeline has priority, writes to x0 are suppressed.
    always_comb begin
        rf_wr_en_o   = 1'b0;
        rf_wr_addr_o = 5'd0;
        rf_wr_data_o = {XLEN{1'b0}};
        if (pipe_wb_en_i) begin
            rf_wr_en_o   = (pipe_wb_rd_i != 5'd0);
            rf_wr_addr_o = pipe_wb_rd_i;
            rf_wr_data_o = pipe_wb_data_i;
        end else if (w_div_wr) begin
            rf_wr_en_o   = (r_pend_rd != 5'd0);
            rf_wr_addr_o = r_pend_rd;
            rf_wr_data_o = w_div_data;
        end else begin
            rf_wr_en_o   = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = w_state_eff;
        case (w_state_eff)
            S_IDLE: begin
                if (w_issue) begin
                    w_next = S_BUSY;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (div_done_i) begin
                    w_next = pipe_wb_en_i ? S_HOLD : S_IDLE;
                end else begin
                    w_next = S_BUSY;
                end
            end
            S_HOLD: begin
                if (pipe_wb_en_i) begin
                    w_next = S_HOLD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, pending destination, held result and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend_rd   <= 5'd0;
            r_hold_data <= {XLEN{1'b0}};
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_pend_rd <= id_wben_i ? id_rd_i : 5'd0;
            end
            if (w_hold_cap) begin
                r_hold_data <= div_result_i;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign div_start_o = w_issue;
    assign div_sel_o   = id_div_sel_i;
    assign stall_o     = w_stall;
    assign busy_o      = (w_state_eff != S_IDLE);
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_div_wb_ctrl.sv
// Directed bench for div_wb_ctrl: issue, hazard stalls, port contention, x0, reset, counter wrap.
module tb_div_wb_ctrl;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid_i, id_div_en_i, id_rs1_used_i, id_rs2_used_i, id_wben_i, flush_i;
    logic [2:0]      id_div_sel_i;
    logic [4:0]      id_rd_i, id_rs1_i, id_rs2_i;
    logic            div_start_o;
    logic [2:0]      div_sel_o;
    logic            div_done_i;
    logic [XLEN-1:0] div_result_i;
    logic            pipe_wb_en_i;
    logic [4:0]      pipe_wb_rd_i;
    logic [XLEN-1:0] pipe_wb_data_i;
    logic            rf_wr_en_o;
    logic [4:0]      rf_wr_addr_o;
    logic [XLEN-1:0] rf_wr_data_o;
    logic            stall_o, busy_o;
    logic [31:0]     stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] R1 = 64'hDEAD_BEEF_0000_0005;
    localparam logic [63:0] R2 = 64'h0123_4567_89AB_CDEF;

    div_wb_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_div_en_i(id_div_en_i), .id_div_sel_i(id_div_sel_i),
        .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .id_wben_i(id_wben_i),
        .flush_i(flush_i), .div_start_o(div_start_o), .div_sel_o(div_sel_o),
        .div_done_i(div_done_i), .div_result_i(div_result_i),
        .pipe_wb_en_i(pipe_wb_en_i), .pipe_wb_rd_i(pipe_wb_rd_i), .pipe_wb_data_i(pipe_wb_data_i),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
        .stall_o(stall_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        id_valid_i = 1'b0; id_div_en_i = 1'b0; id_div_sel_i = 3'd0;
        id_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; id_wben_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic set_div(input logic [4:0] rd, input logic [2:0] sel);
        id_valid_i = 1'b1; id_div_en_i = 1'b1; id_div_sel_i = sel;
        id_rd_i = rd; id_wben_i = 1'b1;
    endtask

    task automatic set_rs1(input logic [4:0] rs);
        clr_id();
        id_valid_i = 1'b1; id_rs1_i = rs; id_rs1_used_i = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clr_id();
        div_done_i = 1'b0; div_result_i = 64'd0;
        pipe_wb_en_i = 1'b0; pipe_wb_rd_i = 5'd0; pipe_wb_data_i = 64'd0;
        step();
        // Reset cycle: a div in ID must not start
        set_div(5'd5, 3'd4);
        #1;
        chk("rst_start", {63'd0, div_start_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        step();
        chk("rst_cnt", {32'd0, stall_cnt_o}, 64'd0);
        chk("rst_wren", {63'd0, rf_wr_en_o}, 64'd0);
        rst = 1'b0;

        // Issue divide to x5
        #1;
        chk("A_start", {63'd0, div_start_o}, 64'd1);
        chk("A_sel", {61'd0, div_sel_o}, 64'd4);
        chk("A_busy0", {63'd0, busy_o}, 64'd0);
        step();
        clr_id();
        #1;
        chk("A_start_pulse", {63'd0, div_start_o}, 64'd0);
        chk("A_busy1", {63'd0, busy_o}, 64'd1);
        step();
        set_rs1(5'd5); #1;
        chk("A_haz_rs1", {63'd0, stall_o}, 64'd1);
        step();
        set_rs1(5'd6); #1;
        chk("A_nohaz_rs1", {63'd0, stall_o}, 64'd0);
        chk("A_cnt1", {32'd0, stall_cnt_o}, 64'd1);
        step();
        clr_id(); set_div(5'd8, 3'd1); #1;
        chk("A_struct", {63'd0, stall_o}, 64'd1);
        chk("A_nostart", {63'd0, div_start_o}, 64'd0);
        step();
        clr_id();
        step(); step(); step(); step();
        chk("A_busy9", {63'd0, busy_o}, 64'd1);
        step();
        set_rs1(5'd5);
        div_done_i = 1'b1; div_result_i = R1; #1;
        chk("A_wren", {63'd0, rf_wr_en_o}, 64'd1);
        chk("A_addr", {59'd0, rf_wr_addr_o}, 64'd5);
        chk("A_data", rf_wr_data_o, R1);
        chk("A_stall_wr", {63'd0, stall_o}, 64'd1);
        chk("A_busy10", {63'd0, busy_o}, 64'd1);
        step();
        div_done_i = 1'b0; #1;
        chk("A_idle", {63'd0, busy_o}, 64'd0);
        chk("A_release", {63'd0, stall_o}, 64'd0);
        chk("A_wren_off", {63'd0, rf_wr_en_o}, 64'd0);
        chk("A_cnt3", {32'd0, stall_cnt_o}, 64'd3);

        // Done coincides with three cycles of pipeline write-back to x7
        clr_id(); set_div(5'd5, 3'd2); #1;
        chk("B_start", {63'd0, div_start_o}, 64'd1);
        step();
        clr_id();
        div_done_i = 1'b1; div_result_i = R2;
        pipe_wb_en_i = 1'b1; pipe_wb_rd_i = 5'd7; pipe_wb_data_i = 64'h11; #1;
        chk("B_p1_addr", {59'd0, rf_wr_addr_o}, 64'd7);
        chk("B_p1_data", rf_wr_data_o, 64'h11);
        step();
        div_done_i = 1'b0; div_result_i = 64'd0; #1;
        chk("B_p2_en", {63'd0, rf_wr_en_o}, 64'd1);
        chk("B_p2_addr", {59'd0, rf_wr_addr_o}, 64'd7);
        chk("B_hold_busy", {63'd0, busy_o}, 64'd1);
        step();
        chk("B_p3_addr", {59'd0, rf_wr_addr_o}, 64'd7);
        step();
        pipe_wb_en_i = 1'b0; pipe_wb_rd_i = 5'd0; pipe_wb_data_i = 64'd0; #1;
        chk("B_h_en", {63'd0, rf_wr_en_o}, 64'd1);
        chk("B_h_addr", {59'd0, rf_wr_addr_o}, 64'd5);
        chk("B_h_data", rf_wr_data_o, R2);
        step();
        chk("B_idle", {63'd0, busy_o}, 64'd0);
        // Stray done in IDLE is ignored
        div_done_i = 1'b1; div_result_i = R1; #1;
        chk("B_stray_en", {63'd0, rf_wr_en_o}, 64'd0);
        step();
        div_done_i = 1'b0;
        chk("B_stray_busy", {63'd0, busy_o}, 64'd0);

        // Divide with rd=0
        set_div(5'd0, 3'd3); #1;
        chk("C_start", {63'd0, div_start_o}, 64'd1);
        step();
        clr_id();
        id_valid_i = 1'b1; id_rs1_used_i = 1'b1; id_rs2_used_i = 1'b1; id_wben_i = 1'b1; #1;
        chk("C_nostall", {63'd0, stall_o}, 64'd0);
        chk("C_busy", {63'd0, busy_o}, 64'd1);
        step();
        div_done_i = 1'b1; div_result_i = R2; #1;
        chk("C_noWr", {63'd0, rf_wr_en_o}, 64'd0);
        step();
        div_done_i = 1'b0; clr_id(); #1;
        chk("C_idle", {63'd0, busy_o}, 64'd0);

        // Counter wrap, then reset in the middle of a divide
        set_div(5'd9, 3'd0);
        step();
        clr_id();
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        #1;
        chk("D_preload", {32'd0, stall_cnt_o}, 64'hFFFF_FFFF);
        set_div(5'd10, 3'd0); #1;
        chk("D_stall", {63'd0, stall_o}, 64'd1);
        step();
        clr_id(); #1;
        chk("D_wrap", {32'd0, stall_cnt_o}, 64'd0);
        set_rs1(5'd9); #1;
        chk("D_haz9", {63'd0, stall_o}, 64'd1);
        step();
        clr_id();
        rst = 1'b1; #1;
        chk("D_rst_busy", {63'd0, busy_o}, 64'd0);
        step();
        rst = 1'b0;
        div_done_i = 1'b1; div_result_i = R1; #1;
        chk("D_post_en", {63'd0, rf_wr_en_o}, 64'd0);
        chk("D_post_busy", {63'd0, busy_o}, 64'd0);
        chk("D_post_cnt", {32'd0, stall_cnt_o}, 64'd0);
        step();
        div_done_i = 1'b0; #1;
        chk("D_idle", {63'd0, busy_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
